crf_multiframe_regbank: RTL and testbench

- Next-generation configuration register file for the upsampling pipeline, sitting between the host AXI4-Lite bus and access_control.
- Adds runtime-programmable source image size and a batched multi-frame sequencer: one host START runs FRAME_NUM frames back-to-back.
- Adds a per-frame counter, sticky write-1-to-clear interrupt status and unmapped-address error responses.

---
 rtl/crf_multiframe_regbank.sv | 279 +++++++++++++++++++++++++++
 tb/tb_crf_multiframe_regbank.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crf_multiframe_regbank.sv
// AXI4-Lite configuration register file with a batched multi-frame sequencer.
// One host START runs FRAME_NUM frames back-to-back, each closed by an UPENDR write from access_control.
module crf_multiframe_regbank #(
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int CRF_DATA_WIDTH  = 32,
  parameter int CRF_ADDR_WIDTH  = 32,
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int DEFAULT_SRC_W   = 960,
  parameter int DEFAULT_SRC_H   = 540
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                    s_axi_awprot,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic [1:0]                    s_axi_bresp,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                    s_axi_arprot,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  input  logic                          ac_crf_wrt,
  input  logic [CRF_ADDR_WIDTH-1:0]     ac_crf_waddr,
  input  logic [CRF_DATA_WIDTH-1:0]     ac_crf_wdata,
  input  logic                          ac_crf_processing,
  output logic                          crf_ac_UPSTART,
  output logic                          crf_ac_UPEND,
  output logic                          crf_ac_wbusy,
  output logic [15:0]                   crf_ac_src_width,
  output logic [15:0]                   crf_ac_src_height,
  output logic                          interrupt_updone
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [5:0] IDX_CTRL      = 6'd0;
  localparam logic [5:0] IDX_UPENDR    = 6'd1;
  localparam logic [5:0] IDX_STATUS    = 6'd2;
  localparam logic [5:0] IDX_IRQ_STAT  = 6'd3;
  localparam logic [5:0] IDX_SRC_W     = 6'd4;
  localparam logic [5:0] IDX_SRC_H     = 6'd5;
  localparam logic [5:0] IDX_FRAME_NUM = 6'd6;
  localparam logic [5:0] IDX_FRAME_CNT = 6'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN, ST_DONE} seq_state_t;

  seq_state_t state_reg, state_next;

  logic                       ready_en_reg;
  logic                       aw_held_reg, w_held_reg;
  logic [5:0]                 aw_idx_reg;
  logic [AXI_DATA_WIDTH-1:0]  w_data_reg;
  logic [STRB_W-1:0]          w_strb_reg;
  logic                       bvalid_reg, rvalid_reg;
  logic [1:0]                 bresp_reg, rresp_reg;
  logic [AXI_DATA_WIDTH-1:0]  rdata_reg;

  logic                       irq_en_reg, irq_done_reg, intr_reg, upend_reg;
  logic [CRF_DATA_WIDTH-1:0]  upendr_reg;
  logic [15:0]                src_w_reg, src_h_reg;
  logic [FRAME_CNT_WIDTH-1:0] frame_num_reg, frame_cnt_reg;

  logic [FRAME_CNT_WIDTH-1:0] cnt_next, cnt_inc;
  logic                       upend_next, done_set;

  logic                       aw_hs, w_hs, ar_hs, commit, aw_mapped, busy;
  logic                       start_cmd, abort_cmd, irq_w1c, frame_done;
  logic [AXI_DATA_WIDTH-1:0]  wmask, mrg_ctrl, mrg_src_w, mrg_src_h, mrg_fnum;
  logic [AXI_DATA_WIDTH-1:0]  rd_data;
  logic [1:0]                 rd_resp;
  logic                       unused_bits;

  // Expand byte strobes to a bit mask for read-modify-write of the holding data.
  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{w_strb_reg[gi]}};
    end
  endgenerate

  function automatic logic [AXI_DATA_WIDTH-1:0] wr_merge(
    input logic [AXI_DATA_WIDTH-1:0] old_val,
    input logic [AXI_DATA_WIDTH-1:0] new_val,
    input logic [AXI_DATA_WIDTH-1:0] mask
  );
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  assign mrg_ctrl  = wr_merge(AXI_DATA_WIDTH'({irq_en_reg, 2'b00}), w_data_reg, wmask);
  assign mrg_src_w = wr_merge(AXI_DATA_WIDTH'(src_w_reg), w_data_reg, wmask);
  assign mrg_src_h = wr_merge(AXI_DATA_WIDTH'(src_h_reg), w_data_reg, wmask);
  assign mrg_fnum  = wr_merge(AXI_DATA_WIDTH'(frame_num_reg), w_data_reg, wmask);

  assign s_axi_awready = ready_en_reg & ~aw_held_reg & ~bvalid_reg;
  assign s_axi_wready  = ready_en_reg & ~w_held_reg & ~bvalid_reg;
  assign s_axi_arready = ready_en_reg & ~rvalid_reg;
  assign aw_hs         = s_axi_awvalid & s_axi_awready;
  assign w_hs          = s_axi_wvalid & s_axi_wready;
  assign ar_hs         = s_axi_arvalid & s_axi_arready;

  // access_control owns the register port in a collision cycle; the host commit waits.
  assign commit     = aw_held_reg & w_held_reg & ~ac_crf_wrt;
  assign aw_mapped  = (aw_idx_reg[5:3] == 3'd0);
  assign busy       = (state_reg == ST_START) || (state_reg == ST_RUN);
  assign start_cmd  = commit && (aw_idx_reg == IDX_CTRL) && w_strb_reg[0] && w_data_reg[0];
  assign abort_cmd  = commit && (aw_idx_reg == IDX_CTRL) && w_strb_reg[0] && w_data_reg[1];
  assign irq_w1c    = commit && (aw_idx_reg == IDX_IRQ_STAT) && w_strb_reg[0] && w_data_reg[0];
  assign frame_done = ac_crf_wrt && (ac_crf_waddr[7:2] == IDX_UPENDR) && ac_crf_wdata[0];

  always_comb begin
    state_next = state_reg;
    cnt_next   = frame_cnt_reg;
    upend_next = upend_reg;
    done_set   = 1'b0;
    cnt_inc    = frame_cnt_reg + 1'b1;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start_cmd && (frame_num_reg != '0)) begin
          state_next = ST_START;
          cnt_next   = '0;
          upend_next = 1'b0;
        end
      end
      ST_START: state_next = ST_RUN;
      ST_RUN: begin
        if (frame_done) begin
          cnt_next = cnt_inc;
          if (cnt_inc == frame_num_reg) begin
            state_next = ST_DONE;
            upend_next = 1'b1;
            done_set   = 1'b1;
          end else begin
            state_next = ST_START;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Abort wins over a START in the same write and leaves counters and status alone.
    if (abort_cmd) begin
      state_next = ST_IDLE;
      cnt_next   = frame_cnt_reg;
      upend_next = upend_reg;
      done_set   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      frame_cnt_reg <= '0;
      upend_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      frame_cnt_reg <= cnt_next;
      upend_reg     <= upend_next;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (s_axi_araddr[7:2])
      IDX_CTRL:      rd_data = AXI_DATA_WIDTH'({irq_en_reg, 2'b00});
      IDX_UPENDR:    rd_data = AXI_DATA_WIDTH'(upendr_reg);
      IDX_STATUS:    rd_data = AXI_DATA_WIDTH'({state_reg == ST_DONE, busy});
      IDX_IRQ_STAT:  rd_data = AXI_DATA_WIDTH'(irq_done_reg);
      IDX_SRC_W:     rd_data = AXI_DATA_WIDTH'(src_w_reg);
      IDX_SRC_H:     rd_data = AXI_DATA_WIDTH'(src_h_reg);
      IDX_FRAME_NUM: rd_data = AXI_DATA_WIDTH'(frame_num_reg);
      IDX_FRAME_CNT: rd_data = AXI_DATA_WIDTH'(frame_cnt_reg);
      default:       rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_reg <= 1'b0;
      aw_held_reg  <= 1'b0;
      w_held_reg   <= 1'b0;
      aw_idx_reg   <= '0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
      rvalid_reg   <= 1'b0;
      rresp_reg    <= RESP_OKAY;
      rdata_reg    <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      if (aw_hs) begin
        aw_held_reg <= 1'b1;
        aw_idx_reg  <= s_axi_awaddr[7:2];
      end else if (commit) begin
        aw_held_reg <= 1'b0;
      end
      if (w_hs) begin
        w_held_reg <= 1'b1;
        w_data_reg <= s_axi_wdata;
        w_strb_reg <= s_axi_wstrb;
      end else if (commit) begin
        w_held_reg <= 1'b0;
      end
      if (commit) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= aw_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_reg && s_axi_bready) begin
        bvalid_reg <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_data;
        rresp_reg  <= rd_resp;
      end else if (rvalid_reg && s_axi_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  // Configuration registers; image geometry and batch length are frozen while a batch runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_reg    <= 1'b0;
      irq_done_reg  <= 1'b0;
      intr_reg      <= 1'b0;
      upendr_reg    <= '0;
      src_w_reg     <= 16'(DEFAULT_SRC_W);
      src_h_reg     <= 16'(DEFAULT_SRC_H);
      frame_num_reg <= FRAME_CNT_WIDTH'(1);
    end else begin
      if (ac_crf_wrt && (ac_crf_waddr[7:2] == IDX_UPENDR)) begin
        upendr_reg <= ac_crf_wdata;
      end
      if (commit) begin
        case (aw_idx_reg)
          IDX_CTRL:      irq_en_reg <= mrg_ctrl[2];
          IDX_SRC_W:     if (!busy) src_w_reg <= mrg_src_w[15:0];
          IDX_SRC_H:     if (!busy) src_h_reg <= mrg_src_h[15:0];
          IDX_FRAME_NUM: if (!busy) frame_num_reg <= mrg_fnum[FRAME_CNT_WIDTH-1:0];
          default: ;
        endcase
      end
      if (done_set) begin
        irq_done_reg <= 1'b1;
      end else if (irq_w1c) begin
        irq_done_reg <= 1'b0;
      end
      intr_reg <= irq_done_reg & irq_en_reg;
    end
  end

  assign s_axi_bvalid      = bvalid_reg;
  assign s_axi_bresp       = bresp_reg;
  assign s_axi_rvalid      = rvalid_reg;
  assign s_axi_rresp       = rresp_reg;
  assign s_axi_rdata       = rdata_reg;
  assign crf_ac_UPSTART    = (state_reg == ST_START);
  assign crf_ac_UPEND      = upend_reg;
  assign crf_ac_wbusy      = aw_held_reg & w_held_reg;
  assign crf_ac_src_width  = src_w_reg;
  assign crf_ac_src_height = src_h_reg;
  assign interrupt_updone  = intr_reg;

  assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_awprot, s_axi_arprot, ac_crf_waddr,
                         ac_crf_processing, mrg_ctrl, mrg_src_w, mrg_src_h, mrg_fnum};

endmodule

// File: tb/tb_crf_multiframe_regbank.sv
// Directed bench for crf_multiframe_regbank: AXI-Lite bus tasks plus one task per feature.
`timescale 1ns/1ps
module tb_crf_multiframe_regbank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        ac_crf_wrt;
  logic [31:0] ac_crf_waddr, ac_crf_wdata;
  logic        ac_crf_processing;
  logic        crf_ac_UPSTART, crf_ac_UPEND, crf_ac_wbusy;
  logic [15:0] crf_ac_src_width, crf_ac_src_height;
  logic        interrupt_updone;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int batch_p0 = 0;

  crf_multiframe_regbank dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .ac_crf_wrt(ac_crf_wrt), .ac_crf_waddr(ac_crf_waddr), .ac_crf_wdata(ac_crf_wdata),
    .ac_crf_processing(ac_crf_processing),
    .crf_ac_UPSTART(crf_ac_UPSTART), .crf_ac_UPEND(crf_ac_UPEND), .crf_ac_wbusy(crf_ac_wbusy),
    .crf_ac_src_width(crf_ac_src_width), .crf_ac_src_height(crf_ac_src_height),
    .interrupt_updone(interrupt_updone)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && crf_ac_UPSTART) pulse_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1; n++;
      if (aw_hs) begin s_axi_awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin s_axi_wvalid = 1'b0;  w_done = 1;  end
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1; n = 0;
    while (!s_axi_bvalid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    resp = s_axi_bresp;
    if (!s_axi_bvalid) begin
      checks++; failures++;
      $display("FAIL write_timeout addr=%h got no bvalid, required bvalid=1", addr);
      resp = 2'bxx;
    end else begin
      @(posedge clk); #1;
    end
    s_axi_bready = 1'b0;
    $display("write addr=%h data=%h strb=%b bresp=%b", addr, data, strb, resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    n = 0;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1; n = 0;
    while (!s_axi_rvalid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    data = s_axi_rdata; resp = s_axi_rresp;
    if (!s_axi_rvalid) begin
      checks++; failures++;
      $display("FAIL read_timeout addr=%h got no rvalid, required rvalid=1", addr);
      data = 'x; resp = 2'bxx;
    end else begin
      @(posedge clk); #1;
    end
    s_axi_rready = 1'b0;
    $display("read  addr=%h rdata=%h rresp=%b", addr, data, resp);
  endtask

  task automatic ac_write(input logic [31:0] addr, input logic [31:0] data);
    ac_crf_waddr = addr; ac_crf_wdata = data; ac_crf_wrt = 1'b1;
    @(posedge clk); #1;
    ac_crf_wrt = 1'b0;
    $display("ac_write addr=%h data=%h", addr, data);
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    rst_n = 1'b0;
    cyc(3);
    obs = {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
           crf_ac_UPSTART, crf_ac_UPEND, crf_ac_wbusy, interrupt_updone};
    checks++;
    if (obs !== 9'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=%b", obs, 9'h0);
    end
    rst_n = 1'b1;
    cyc(1);
    obs = {6'b0, s_axi_awready, s_axi_wready, s_axi_arready};
    checks++;
    if (obs !== 9'b111) begin
      failures++;
      $display("FAIL ready_after_reset got=%b required=%b", obs[2:0], 3'b111);
    end
  endtask

  task automatic test_defaults();
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(32'h10, d, r);
    checks++;
    if (d !== 32'd960 || r !== 2'b00) begin failures++; $display("FAIL default_src_w got=%0d/%b required=960/00", d, r); end
    axi_read(32'h14, d, r);
    checks++;
    if (d !== 32'd540 || r !== 2'b00) begin failures++; $display("FAIL default_src_h got=%0d/%b required=540/00", d, r); end
    axi_read(32'h18, d, r);
    checks++;
    if (d !== 32'd1 || r !== 2'b00) begin failures++; $display("FAIL default_frame_num got=%0d/%b required=1/00", d, r); end
    checks++;
    if (crf_ac_src_width !== 16'd960 || crf_ac_src_height !== 16'd540) begin
      failures++;
      $display("FAIL default_size_ports got=%0d,%0d required=960,540", crf_ac_src_width, crf_ac_src_height);
    end
  endtask

  task automatic test_batch();
    logic [31:0] d;
    logic [1:0]  r;
    int p0;
    axi_write(32'h18, 32'd3, 4'hF, r);
    p0 = pulse_cnt;
    axi_write(32'h00, 32'h5, 4'hF, r);
    for (int i = 0; i < 3; i++) begin
      cyc(2);
      ac_write(32'h04, 32'h1);
    end
    cyc(2);
    checks++;
    if (pulse_cnt - p0 !== 3) begin failures++; $display("FAIL batch_pulses got=%0d required=3", pulse_cnt - p0); end
    checks++;
    if (crf_ac_UPEND !== 1'b1 || interrupt_updone !== 1'b1) begin
      failures++;
      $display("FAIL batch_end got upend=%b irq=%b required 1/1", crf_ac_UPEND, interrupt_updone);
    end
    axi_read(32'h1C, d, r);
    checks++;
    if (d !== 32'd3) begin failures++; $display("FAIL batch_frame_cnt got=%0d required=3", d); end
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL batch_status got=%h required=2", d); end
    axi_write(32'h0C, 32'h1, 4'hF, r);
    checks++;
    if (interrupt_updone !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b required=0", interrupt_updone); end
    axi_read(32'h0C, d, r);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL irq_stat_cleared got=%h required=0", d); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    logic [1:0]  r;
    s_axi_wdata = 32'd4; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
    cyc(2);
    s_axi_awaddr = 32'h18; s_axi_awvalid = 1'b1;
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    checks++;
    if (crf_ac_wbusy !== 1'b1) begin failures++; $display("FAIL collision_wbusy got=%b required=1", crf_ac_wbusy); end
    ac_crf_waddr = 32'h04; ac_crf_wdata = 32'h0; ac_crf_wrt = 1'b1;
    @(posedge clk); #1;
    ac_crf_wrt = 1'b0;
    checks++;
    if (crf_ac_wbusy !== 1'b1 || s_axi_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL collision_delay got wbusy=%b bvalid=%b required 1/0", crf_ac_wbusy, s_axi_bvalid);
    end
    @(posedge clk); #1;
    checks++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 || crf_ac_wbusy !== 1'b0) begin
      failures++;
      $display("FAIL collision_commit got bvalid=%b bresp=%b wbusy=%b required 1/00/0", s_axi_bvalid, s_axi_bresp, crf_ac_wbusy);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0) begin
        failures++;
        $display("FAIL bready_hold cycle=%0d got bvalid=%b awready=%b required 1/0", i, s_axi_bvalid, s_axi_awready);
      end
      @(posedge clk); #1;
    end
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    checks++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
      failures++;
      $display("FAIL bready_release got bvalid=%b awready=%b required 0/1", s_axi_bvalid, s_axi_awready);
    end
    $display("collision write addr=18 data=4 committed after ac_crf_wrt");
    axi_read(32'h18, d, r);
    checks++;
    if (d !== 32'd4) begin failures++; $display("FAIL collision_frame_num got=%0d required=4", d); end
    axi_read(32'h04, d, r);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL collision_upendr got=%h required=0", d); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(32'h40, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin failures++; $display("FAIL unmapped_read got=%h/%b required=0/10", d, r); end
    axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, r);
    checks++;
    if (r !== 2'b10) begin failures++; $display("FAIL unmapped_write_resp got=%b required=10", r); end
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL unmapped_status got=%h required=2", d); end
    axi_read(32'h18, d, r);
    checks++;
    if (d !== 32'd4) begin failures++; $display("FAIL unmapped_frame_num got=%0d required=4", d); end
    axi_read(32'h10, d, r);
    checks++;
    if (d !== 32'd960) begin failures++; $display("FAIL unmapped_src_w got=%0d required=960", d); end
  endtask

  task automatic test_busy_drop();
    logic [31:0] d;
    logic [1:0]  r;
    batch_p0 = pulse_cnt;
    axi_write(32'h00, 32'h5, 4'hF, r);
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL busy_status got=%h required=1", d); end
    axi_write(32'h10, 32'd1920, 4'b0001, r);
    checks++;
    if (r !== 2'b00) begin failures++; $display("FAIL busy_write_resp got=%b required=00", r); end
    axi_read(32'h10, d, r);
    checks++;
    if (d !== 32'd960 || crf_ac_src_width !== 16'd960) begin
      failures++;
      $display("FAIL busy_drop got=%0d port=%0d required=960", d, crf_ac_src_width);
    end
    checks++;
    if (crf_ac_UPEND !== 1'b0) begin failures++; $display("FAIL restart_upend got=%b required=0", crf_ac_UPEND); end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    logic [1:0]  r;
    int p1;
    cyc(1);
    ac_write(32'h04, 32'h1);
    cyc(2);
    checks++;
    if (pulse_cnt - batch_p0 !== 2) begin failures++; $display("FAIL abort_pre_pulses got=%0d required=2", pulse_cnt - batch_p0); end
    axi_write(32'h00, 32'h2, 4'hF, r);
    axi_read(32'h08, d, r);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL abort_status got=%h required=0", d); end
    axi_read(32'h1C, d, r);
    checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL abort_frame_cnt got=%0d required=1", d); end
    checks++;
    if (crf_ac_UPEND !== 1'b0) begin failures++; $display("FAIL abort_upend got=%b required=0", crf_ac_UPEND); end
    axi_write(32'h10, 32'd1920, 4'b0001, r);
    axi_read(32'h10, d, r);
    checks++;
    if (d !== 32'h380 || crf_ac_src_width !== 16'h380) begin
      failures++;
      $display("FAIL idle_strb_write got=%h port=%h required=380", d, crf_ac_src_width);
    end
    p1 = pulse_cnt;
    axi_write(32'h00, 32'h5, 4'hF, r);
    axi_read(32'h1C, d, r);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL restart_frame_cnt got=%0d required=0", d); end
    cyc(5);
    checks++;
    if (pulse_cnt - p1 !== 1) begin failures++; $display("FAIL restart_pulses got=%0d required=1", pulse_cnt - p1); end
    axi_write(32'h00, 32'h2, 4'hF, r);
  endtask

  initial begin
    s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_awprot = 0;
    s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_bready = 0;
    s_axi_arvalid = 0; s_axi_araddr = 0; s_axi_arprot = 0; s_axi_rready = 0;
    ac_crf_wrt = 0; ac_crf_waddr = 0; ac_crf_wdata = 0; ac_crf_processing = 0;
    @(posedge clk); #1;
    test_reset();
    test_defaults();
    test_batch();
    test_collision();
    test_unmapped();
    test_busy_drop();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
